// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and line levels.
// The receiver imports the same package so both ends agree on framing.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_if.sv
// RS-232 line and AXI-Stream byte interfaces used by the UART blocks.
// rxd is the DCE transmit line seen by the DTE.
interface rs232;
  import uart_pkg::*;

  localparam logic MARK  = LINE_MARK;
  localparam logic SPACE = LINE_SPACE;

  logic rxd;

  modport dce (output rxd);
  modport dte (input rxd);
endinterface

interface axis;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count; restart holds it at zero so every state starts a fresh bit period.
module uart_baud #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register in front of a start/8 data
// MSB-first/stop shifter, so a pending byte starts right after the last stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic reset,
  rs232.dce    dce,
  axis.slave   slave,
  output logic busy
);

  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_t state, state_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [UART_DATA_BITS-1:0] hold;
  logic                      hold_full, hold_full_next;
  logic [BW-1:0]             bit_cnt, bit_cnt_next;
  logic                      stop_cnt, stop_cnt_next;
  logic                      tick, restart, take, load, line_d;

  uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign take = slave.tvalid && slave.tready;
  assign busy = (state != IDLE) || hold_full;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    load          = 1'b0;
    line_d        = LINE_MARK;

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_d = LINE_SPACE;
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        line_d = shift[UART_DATA_BITS-1];
        if (tick) begin
          shift_next   = {shift[UART_DATA_BITS-2:0], 1'b0};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next    = STOP;
            stop_cnt_next = 1'b0;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            // A pending byte skips IDLE so frames run back to back.
            if (hold_full) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) shift_next = hold;

    hold_full_next = (hold_full && !load) || take;
    restart        = (state == IDLE) || (state_next != state);
  end

  // NOTE: data registers are reset as well; it is cheap here and keeps X off the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      dce.rxd      <= LINE_MARK;
      slave.tready <= 1'b0;
    end else begin
      state        <= state_next;
      shift        <= shift_next;
      hold_full    <= hold_full_next;
      bit_cnt      <= bit_cnt_next;
      stop_cnt     <= stop_cnt_next;
      dce.rxd      <= line_d;
      slave.tready <= !hold_full_next;
      if (take) hold <= slave.tdata;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) checked every cycle
// against a frame-timeline model, plus literal spot checks and a loopback receiver.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  axis   ax0 (), ax1 ();
  rs232  r0 (), r1 ();

  logic       tv [2];
  logic [7:0] td [2];
  logic       rxd_w [2], rdy_w [2], busy_w [2];
  logic       busy0, busy1;

  assign ax0.tvalid = tv[0];
  assign ax0.tdata  = td[0];
  assign ax1.tvalid = tv[1];
  assign ax1.tdata  = td[1];
  assign rxd_w[0]   = r0.rxd;
  assign rxd_w[1]   = r1.rxd;
  assign rdy_w[0]   = ax0.tready;
  assign rdy_w[1]   = ax1.tready;
  assign busy_w[0]  = busy0;
  assign busy_w[1]  = busy1;

  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .dce(r0), .slave(ax0), .busy(busy0)
  );
  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .dce(r1), .slave(ax1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- behavioural model: frame position timeline ----------------
  function automatic int flen(input int i);
    return (i == 0) ? 10 * N : 11 * N;
  endfunction

  function automatic logic line_of(input logic [7:0] b, input int pos);
    int k;
    k = pos / N;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[8-k];
    return 1'b1;
  endfunction

  bit         m_act [2], m_hold_v [2];
  logic [7:0] m_byte [2], m_hold [2];
  int         m_pos [2];
  logic       m_rxd [2], m_rdy [2], m_busy [2];
  logic [7:0] exp0 [$], exp1 [$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_hold_v[i] = 1'b0; m_pos[i] = 0;
        m_rxd[i] = 1'b1; m_rdy[i] = 1'b0; m_busy[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic xfer;
        xfer = tv[i] && m_rdy[i];
        m_rxd[i] = m_act[i] ? line_of(m_byte[i], m_pos[i]) : 1'b1;
        if (m_act[i]) begin
          m_pos[i]++;
          if (m_pos[i] == flen(i)) begin
            if (i == 0) exp0.push_back(m_byte[i]); else exp1.push_back(m_byte[i]);
            m_act[i] = 1'b0;
          end
        end
        if (!m_act[i] && m_hold_v[i]) begin
          m_act[i] = 1'b1; m_byte[i] = m_hold[i]; m_pos[i] = 0; m_hold_v[i] = 1'b0;
        end
        if (xfer) begin
          m_hold_v[i] = 1'b1; m_hold[i] = td[i];
        end
        m_rdy[i]  = !m_hold_v[i];
        m_busy[i] = m_act[i] || m_hold_v[i];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rxd[%0d]", i),   32'(rxd_w[i]),  32'(m_rxd[i]));
        check($sformatf("tready[%0d]", i), 32'(rdy_w[i]), 32'(m_rdy[i]));
        check($sformatf("busy[%0d]", i),  32'(busy_w[i]), 32'(m_busy[i]));
      end
    end
  end

  // ---------------- loopback receiver (mid-bit sampling) ----------------
  bit         rx_on [2];
  int         rx_cnt [2];
  logic [7:0] rx_sh [2];
  logic [7:0] got0 [$], got1 [$];

  initial forever begin
    @(posedge clk or posedge reset);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rx_on[i] = 1'b0;
      end else if (!rx_on[i]) begin
        if (rxd_w[i] == 1'b0) begin
          rx_on[i] = 1'b1; rx_cnt[i] = 0;
        end
      end else begin
        rx_cnt[i]++;
        if (rx_cnt[i] % N == N / 2) begin
          int k;
          k = rx_cnt[i] / N;
          if (k == 0 && rxd_w[i] != 1'b0) rx_on[i] = 1'b0;
          else if (k >= 1 && k <= 8) rx_sh[i] = {rx_sh[i][6:0], rxd_w[i]};
          else if (k == 9) begin
            if (rxd_w[i] == 1'b1) begin
              if (i == 0) got0.push_back(rx_sh[i]); else got1.push_back(rx_sh[i]);
            end
            rx_on[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic send(input int i, input logic [7:0] b, output int h);
    int n;
    @(negedge clk);
    tv[i] = 1'b1;
    td[i] = b;
    n = 0;
    while (rdy_w[i] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check($sformatf("handshake timeout[%0d]", i), 32'd0, 32'd1);
      tv[i] = 1'b0;
      h = cyc;
      return;
    end
    @(posedge clk);
    #1 h = cyc;
    @(negedge clk);
    tv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy_w[i] !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check($sformatf("idle timeout[%0d]", i), 32'd0, 32'd1);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int h, h1, h2, h3;
    int n0;
    logic [7:0] a5_line;
    logic [7:0] c3_line;
    logic       prev_rdy [2];

    a5_line = 8'b1010_0101;
    c3_line = 8'b0011_1100;
    tv[0] = 1'b0; tv[1] = 1'b0; td[0] = '0; td[1] = '0;

    #1 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset rxd",    32'(rxd_w[i]),  32'(r0.MARK));
      check("reset tready", 32'(rdy_w[i]),  32'd0);
      check("reset busy",   32'(busy_w[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("tready after reset[0]", 32'(rdy_w[0]), 32'd1);
    check("tready after reset[1]", 32'(rdy_w[1]), 32'd1);

    // Single 0xA5 frame, 1 stop bit.
    send(0, 8'hA5, h);
    check("a5 tready pending", 32'(rdy_w[0]), 32'd0);
    wait_until(h + 1);
    check("a5 rxd before start", 32'(rxd_w[0]), 32'(r0.MARK));
    check("a5 busy early", 32'(busy_w[0]), 32'd1);
    check("a5 tready reopens", 32'(rdy_w[0]), 32'd1);
    wait_until(h + 2);
    check("a5 start edge", 32'(rxd_w[0]), 32'(r0.SPACE));
    for (int k = 0; k < 8; k++) begin
      wait_until(h + 2 + N * (k + 1) + N / 2);
      check($sformatf("a5 bit%0d", k), 32'(rxd_w[0]), 32'(a5_line[7-k]));
    end
    wait_until(h + 2 + 9 * N + N / 2);
    check("a5 stop", 32'(rxd_w[0]), 32'(r0.MARK));
    wait_until(h + 80);
    check("a5 busy last", 32'(busy_w[0]), 32'd1);
    wait_until(h + 81);
    check("a5 busy falls", 32'(busy_w[0]), 32'd0);

    // Back-to-back 0x00 then 0xFF.
    wait_idle(0);
    send(0, 8'h00, h1);
    send(0, 8'hFF, h2);
    check("b2b second handshake", 32'(h2 - h1), 32'd2);
    check("b2b tready pending", 32'(rdy_w[0]), 32'd0);
    wait_until(h1 + 80);
    check("b2b tready held", 32'(rdy_w[0]), 32'd0);
    wait_until(h1 + 81);
    check("b2b last stop", 32'(rxd_w[0]), 32'(r0.MARK));
    check("b2b tready after load", 32'(rdy_w[0]), 32'd1);
    wait_until(h1 + 82);
    check("b2b second start", 32'(rxd_w[0]), 32'(r0.SPACE));
    wait_until(h1 + 160);
    check("b2b busy last", 32'(busy_w[0]), 32'd1);
    wait_until(h1 + 161);
    check("b2b busy falls", 32'(busy_w[0]), 32'd0);

    // Two stop bits, 0x3C.
    send(1, 8'h3C, h);
    wait_until(h + 2 + 8 * N + N / 2);
    check("3c bit7", 32'(rxd_w[1]), 32'(c3_line[0]));
    wait_until(h + 73);
    check("3c last data cycle", 32'(rxd_w[1]), 32'(r1.SPACE));
    wait_until(h + 74);
    check("3c first stop", 32'(rxd_w[1]), 32'(r1.MARK));
    wait_until(h + 88);
    check("3c busy last", 32'(busy_w[1]), 32'd1);
    wait_until(h + 89);
    check("3c last stop", 32'(rxd_w[1]), 32'(r1.MARK));
    check("3c busy falls", 32'(busy_w[1]), 32'd0);

    // Backpressure: third byte offered while one shifts and one waits.
    wait_idle(0);
    send(0, 8'h11, h1);
    send(0, 8'h22, h2);
    send(0, 8'h33, h3);
    check("backpressure third handshake", 32'(h3 - h1), 32'd82);
    wait_idle(0);

    // Randomized traffic on both instances.
    @(negedge clk);
    prev_rdy[0] = rdy_w[0];
    prev_rdy[1] = rdy_w[1];
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!tv[i] || prev_rdy[i]) begin
          tv[i] = ($urandom_range(0, 3) != 0);
          td[i] = 8'($urandom);
        end
        prev_rdy[i] = rdy_w[i];
      end
    end
    @(negedge clk);
    if (tv[0] && rdy_w[0]) @(negedge clk);
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    // Reset in the middle of 0x81's data bits, then a clean 0x42.
    send(0, 8'h81, h);
    wait_until(h + 2 + 5 * N + 2);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midframe reset rxd",    32'(rxd_w[i]),  32'(r0.MARK));
      check("midframe reset tready", 32'(rdy_w[i]),  32'd0);
      check("midframe reset busy",   32'(busy_w[i]), 32'd0);
    end
    n0 = got0.size();
    @(negedge clk);
    reset = 1'b0;
    send(0, 8'h42, h);
    wait_idle(0);
    wait_idle(1);
    repeat (20) @(negedge clk);

    check("rx after reset count", 32'(got0.size() - n0), 32'd1);
    if (got0.size() > n0) check("rx after reset byte", 32'(got0[n0]), 32'h42);
    check("loopback count[0]", 32'(got0.size()), 32'(exp0.size()));
    check("loopback count[1]", 32'(got1.size()), 32'(exp1.size()));
    for (int j = 0; j < got0.size() && j < exp0.size(); j++)
      check($sformatf("loopback[0][%0d]", j), 32'(got0[j]), 32'(exp0[j]));
    for (int j = 0; j < got1.size() && j < exp1.size(); j++)
      check($sformatf("loopback[1][%0d]", j), 32'(got1[j]), 32'(exp1[j]));

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART: accepts bytes on an AXI-Stream slave port and serialises them onto the RS-232 line toward the DTE. Frame is start, 8 data bits MSB-first, 1 or 2 stop bits, no parity. The bit order and bit period match the team's UART receiver so the two ends interoperate. A one-byte holding register decouples the stream handshake from the shifter, so back-to-back frames leave no idle gap.

## Interface
- `CLKS_PER_BIT`, 8: clock cycles per bit period; ≥ 2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `dce`  rs232.dce  modport  drives `dce.rxd` (DCE transmit line); uses the interface's `MARK`/`SPACE` constants.
- `slave`  axis.slave  `tdata[7:0]`, `tvalid` in; `tready` out; byte to send.
- `busy`  output  1  high while a frame is on the line or the holding register is full.

## Operation
- Reset values (asynchronous): `dce.rxd` = `MARK`, `slave.tready` = 0, `busy` = 0, state = IDLE, holding register empty, all counters 0.
- `tready` is registered. It equals "holding register empty" and rises on the first clock edge after `reset` deasserts.
- A transfer happens when `tvalid && tready` at a clock edge. `tdata` is captured into the holding register, which becomes full and drops `tready` on that same edge.
- States:
  - IDLE: line at MARK. If the holding register is full, move it into the shift register, empty the holding register, go to START.
  - START: line at SPACE for `CLKS_PER_BIT` cycles, then go to DATA with bit count 0.
  - DATA: line = `shift[7]` for `CLKS_PER_BIT` cycles per bit. At each bit-period end, shift left by one and increment the count. After bit 7 (count wraps 7→0), go to STOP.
  - STOP: line at MARK for `STOP_BITS*CLKS_PER_BIT` cycles. On the last cycle: if the holding register is full, load the shifter and go directly to START; otherwise go to IDLE.
- Bit timer: width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, reloads to 0 on every state transition, and wraps at each bit-period end.
- The holding register can accept a new byte during any frame state. Only one byte may be pending; `tready` stays 0 until the shifter takes it.
- Simultaneous events: if the shifter takes the pending byte on the same edge that `tvalid` arrives, `tready` was 0, so no transfer occurs. `tready` rises on the next edge.
- `busy` = (state ≠ IDLE) || holding register full.
- Reset mid-frame aborts the frame. The line returns to MARK immediately (asynchronous) and the pending byte is discarded.

## Timing
- Latency: a handshake at edge N in IDLE drives `rxd` = SPACE from edge N+2. Edge N+1 loads the shifter and enters START; `rxd` is registered from state.
- Frame length: exactly `(9+STOP_BITS)*CLKS_PER_BIT` cycles of line activity.
- Back-to-back: the next start bit begins on the cycle immediately after the final stop-bit cycle, with no extra MARK cycles.
- Throughput: one byte per `(9+STOP_BITS)*CLKS_PER_BIT` cycles. `tready` re-asserts one cycle after each shifter load.
- `rxd` is driven from a flop; no combinational path from `tdata`/`tvalid` to `rxd` or `tready`.

## Structure
- `uart_pkg`: the `state_t` enum {IDLE, START, DATA, STOP} and `UART_DATA_BITS` = 8. The receiver adopts the same package.
- Natural sub-module: `uart_baud`. It holds the bit timer, takes a `restart` input, and outputs a one-cycle `tick` at bit-period end. `uart_tx` holds the FSM, shifter, holding register and stop counter.

## Test plan
- Reset: assert `reset` mid-clock → `rxd` = MARK, `tready` = 0, `busy` = 0 immediately; after release, `tready` = 1 on the next edge.
- Single byte, `CLKS_PER_BIT`=8, `STOP_BITS`=1: send 0xA5 → line carries SPACE, then 1,0,1,0,0,1,0,1, then MARK, 8 cycles each. SPACE starts 2 cycles after the handshake; `busy` falls after 80 line cycles.
- Back-to-back: hold `tvalid` with 0x00 then 0xFF → the second start bit immediately follows the first stop bit, and the total busy line time is 160 cycles. `tready` is 0 while 0xFF is pending.
- `STOP_BITS`=2, byte 0x3C → stop interval of 16 MARK cycles; frame is 88 cycles.
- Backpressure: offer a third byte while one is shifting and one is pending → `tready` stays 0 until the shifter loads. No byte is lost or duplicated; a loopback into the UART receiver returns the same sequence.
- Reset mid-DATA (after bit 3 of 0x81) → line MARK at once. A later 0x42 is transmitted cleanly, and the receiver sees only 0x42.
